// File: rtl/stream_demux_pkg.sv
// Purpose: shared types and defaults for the 1-to-2 stream demux.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package stream_demux_pkg;

  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 2;

  typedef logic [31:0] word_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_e;

endpackage

// File: rtl/stream_demux_fifo.sv
// Purpose: small synchronous FIFO, one per demux output port.
// Latency: a word pushed at edge N is at the head after edge N when the FIFO was empty.
// Backpressure: push is ignored while full (even if popping); pop is ignored while empty.
//
// Ports:
//   clk_i, rst_i      rising-edge clock, synchronous active-high reset
//   push, wdata       write strobe and word
//   pop               advance the read pointer
//   rdata             head entry (raw, not qualified by empty)
//   full, empty       registered status flags
//   count             occupancy, 0..DEPTH
module stream_demux_fifo
  import stream_demux_pkg::*;
#(
  parameter  int DW    = DW_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  logic          full_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    count_nxt = count_q;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH for free.
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_nxt;
      // Full is kept as its own flop so the upstream ready never sees a compare chain.
      full_q  <= (count_nxt == CW'(DEPTH));
    end
  end

  // Storage is not reset: contents are unreachable once the pointers are cleared.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

  assign rdata = mem[rptr_q];
  assign full  = full_q;
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/stream_demux_1to2.sv
// Purpose: steer one valid/ready word stream to port A (se_i=0) or port B (se_i=1), each behind its own FIFO.
// Latency: 1 cycle from accepted input to x_valid_o when the target FIFO was empty.
// Backpressure: in_ready_o drops only when the selected FIFO is full; a stalled port never blocks the other.
//
// Ports:
//   clk_i, rst_i                     rising-edge clock, synchronous active-high reset
//   in_valid_i/in_ready_o/in_data_i  input stream; se_i picks the destination with the word
//   a_valid_o/a_ready_i/a_data_o     port A head (data forced to 0 when not valid)
//   b_valid_o/b_ready_i/b_data_o     port B head (data forced to 0 when not valid)
//   a_count_o, b_count_o             FIFO occupancy
// Optional (STREAM_DEMUX_PERF_CNT_EN): a_xfer_cnt_o, b_xfer_cnt_o, stall_cnt_o, 32-bit wrapping counters.
module stream_demux_1to2
  import stream_demux_pkg::*;
#(
  parameter  int DW    = DW_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  input  logic          se_i,
  output logic          a_valid_o,
  input  logic          a_ready_i,
  output logic [DW-1:0] a_data_o,
  output logic          b_valid_o,
  input  logic          b_ready_i,
  output logic [DW-1:0] b_data_o,
  output logic [CW-1:0] a_count_o,
  output logic [CW-1:0] b_count_o
`ifdef STREAM_DEMUX_PERF_CNT_EN
  ,
  output logic [31:0]   a_xfer_cnt_o,
  output logic [31:0]   b_xfer_cnt_o,
  output logic [31:0]   stall_cnt_o
`endif
);

  port_sel_e     sel;
  logic          a_full;
  logic          b_full;
  logic          a_empty;
  logic          b_empty;
  logic [DW-1:0] a_rdata;
  logic [DW-1:0] b_rdata;
  logic          in_fire;
  logic          a_push;
  logic          b_push;
  logic          a_pop;
  logic          b_pop;

  assign sel = port_sel_e'(se_i);

  // Ready depends only on registered full flags and the select, never on the
  // downstream readies, so no combinational path crosses the block.
  assign in_ready_o = (sel == PORT_B) ? !b_full : !a_full;
  assign in_fire    = in_valid_i && in_ready_o;
  assign a_push     = in_fire && (sel == PORT_A);
  assign b_push     = in_fire && (sel == PORT_B);

  assign a_valid_o  = !a_empty;
  assign b_valid_o  = !b_empty;
  assign a_pop      = a_valid_o && a_ready_i;
  assign b_pop      = b_valid_o && b_ready_i;
  assign a_data_o   = a_valid_o ? a_rdata : '0;
  assign b_data_o   = b_valid_o ? b_rdata : '0;

  stream_demux_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (a_push),
    .wdata (in_data_i),
    .pop   (a_pop),
    .rdata (a_rdata),
    .full  (a_full),
    .empty (a_empty),
    .count (a_count_o)
  );

  stream_demux_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (b_push),
    .wdata (in_data_i),
    .pop   (b_pop),
    .rdata (b_rdata),
    .full  (b_full),
    .empty (b_empty),
    .count (b_count_o)
  );

`ifdef STREAM_DEMUX_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_xfer_cnt_o <= '0;
      b_xfer_cnt_o <= '0;
      stall_cnt_o  <= '0;
    end else begin
      if (a_pop)                      a_xfer_cnt_o <= a_xfer_cnt_o + 32'd1;
      if (b_pop)                      b_xfer_cnt_o <= b_xfer_cnt_o + 32'd1;
      if (in_valid_i && !in_ready_o)  stall_cnt_o  <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Purpose: self-checking bench for stream_demux_1to2 (directed vectors plus a scoreboarded stress run).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: upstream holds word and select while stalled, as the block expects.
module tb_stream_demux_1to2;
  import stream_demux_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  word_t       in_data_i;
  logic        se_i;
  logic        a_valid_o;
  logic        a_ready_i;
  word_t       a_data_o;
  logic        b_valid_o;
  logic        b_ready_i;
  word_t       b_data_o;
  logic [1:0]  a_count_o;
  logic [1:0]  b_count_o;
`ifdef STREAM_DEMUX_PERF_CNT_EN
  logic [31:0] a_xfer_cnt_o;
  logic [31:0] b_xfer_cnt_o;
  logic [31:0] stall_cnt_o;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  stream_demux_1to2 dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_data_i    (in_data_i),
    .se_i         (se_i),
    .a_valid_o    (a_valid_o),
    .a_ready_i    (a_ready_i),
    .a_data_o     (a_data_o),
    .b_valid_o    (b_valid_o),
    .b_ready_i    (b_ready_i),
    .b_data_o     (b_data_o),
    .a_count_o    (a_count_o),
    .b_count_o    (b_count_o)
`ifdef STREAM_DEMUX_PERF_CNT_EN
    ,
    .a_xfer_cnt_o (a_xfer_cnt_o),
    .b_xfer_cnt_o (b_xfer_cnt_o),
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic sel, input word_t w);
    in_valid_i = 1'b1;
    se_i       = sel;
    in_data_i  = w;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i      = 1'b0;
    in_valid_i = 1'b0;
    se_i       = 1'b0;
    #1;
  endtask

  // Stress-run state.
  word_t qa[$];
  word_t qb[$];
  int    sent;
  int    cyc;
  logic  hold;
  logic  exp_rdy;

  initial begin
    rst_i      = 1'b1;
    in_valid_i = 1'b0;
    in_data_i  = '0;
    se_i       = 1'b0;
    a_ready_i  = 1'b0;
    b_ready_i  = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    #1;

    // Reset in the middle of traffic: one word parked in A, input still valid.
    push(1'b0, 32'hAAAA_0001);
    tick();
    chk("pre_rst_a_count", 32'(a_count_o), 32'd1);
    push(1'b1, 32'hBBBB_0001);
    do_reset();
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);
    chk("rst_a_valid",  32'(a_valid_o),  32'd0);
    chk("rst_b_valid",  32'(b_valid_o),  32'd0);
    chk("rst_a_data",   a_data_o,        32'd0);
    chk("rst_b_data",   b_data_o,        32'd0);
    chk("rst_a_count",  32'(a_count_o),  32'd0);
    chk("rst_b_count",  32'(b_count_o),  32'd0);

    // Steering with both consumers ready.
    a_ready_i = 1'b1;
    b_ready_i = 1'b1;
    push(1'b0, 32'h1111_1111);
    tick();
    chk("steer_a_valid", 32'(a_valid_o), 32'd1);
    chk("steer_a_data",  a_data_o,       32'h1111_1111);
    chk("steer_b_idle",  32'(b_valid_o), 32'd0);
    push(1'b1, 32'h2222_2222);
    tick();
    chk("steer_b_valid", 32'(b_valid_o), 32'd1);
    chk("steer_b_data",  b_data_o,       32'h2222_2222);
    chk("steer_a_drain", 32'(a_valid_o), 32'd0);
    in_valid_i = 1'b0;
    tick();
    chk("steer_b_drain", 32'(b_count_o), 32'd0);

    // Back-pressure on A must not block B.
    a_ready_i = 1'b0;
    push(1'b0, 32'hA000_0001);
    tick();
    push(1'b0, 32'hA000_0002);
    tick();
    chk("full_a_count", 32'(a_count_o), 32'd2);
    push(1'b0, 32'hA000_0003);
    #1;
    chk("full_in_ready", 32'(in_ready_o), 32'd0);
    tick();
    chk("full_hold_count", 32'(a_count_o), 32'd2);
    push(1'b1, 32'hB000_0001);
    #1;
    chk("full_b_ready", 32'(in_ready_o), 32'd1);
    tick();
    chk("full_b_data", b_data_o, 32'hB000_0001);
    in_valid_i = 1'b0;
    tick();
    chk("full_b_gone", 32'(b_valid_o), 32'd0);
    // Full FIFO refuses a push even while it pops.
    a_ready_i = 1'b1;
    push(1'b0, 32'hA000_0004);
    #1;
    chk("full_pop_ready", 32'(in_ready_o), 32'd0);
    chk("full_head0", a_data_o, 32'hA000_0001);
    tick();
    in_valid_i = 1'b0;
    chk("full_pop_count", 32'(a_count_o), 32'd1);
    chk("full_head1", a_data_o, 32'hA000_0002);
    tick();
    chk("full_empty", 32'(a_count_o), 32'd0);

    // Simultaneous push/pop at count 1, five round-trips across the pointer wrap.
    a_ready_i = 1'b0;
    push(1'b0, 32'hC000_0000);
    tick();
    a_ready_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      push(1'b0, 32'hC000_0000 + 32'(i));
      #1;
      chk("pp_head_before", a_data_o, 32'hC000_0000 + 32'(i - 1));
      tick();
      chk("pp_count", 32'(a_count_o), 32'd1);
      chk("pp_head_after", a_data_o, 32'hC000_0000 + 32'(i));
    end
    in_valid_i = 1'b0;
    tick();
    chk("pp_drained", 32'(a_count_o), 32'd0);

    // Stress: random words, select and readies against a per-port scoreboard.
    sent = 0;
    cyc  = 0;
    hold = 1'b0;
    while (sent < 10000 && cyc < 60000) begin
      if (!hold) begin
        in_valid_i = ($urandom_range(0, 3) != 0);
        in_data_i  = $urandom;
        se_i       = 1'($urandom_range(0, 1));
      end
      a_ready_i = ($urandom_range(0, 2) != 0);
      b_ready_i = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = se_i ? (qb.size() < 2) : (qa.size() < 2);
      chk("st_in_ready", 32'(in_ready_o), 32'(exp_rdy));
      chk("st_a_valid",  32'(a_valid_o),  32'(qa.size() != 0));
      chk("st_b_valid",  32'(b_valid_o),  32'(qb.size() != 0));
      if (a_valid_o && a_ready_i && qa.size() != 0) chk("st_a_data", a_data_o, qa.pop_front());
      if (b_valid_o && b_ready_i && qb.size() != 0) chk("st_b_data", b_data_o, qb.pop_front());
      if (in_valid_i && exp_rdy) begin
        if (se_i) qb.push_back(in_data_i);
        else      qa.push_back(in_data_i);
        sent++;
        hold = 1'b0;
      end else begin
        hold = in_valid_i;
      end
      tick();
      cyc++;
    end
    chk("st_all_sent", 32'(sent), 32'd10000);
    in_valid_i = 1'b0;
    a_ready_i  = 1'b1;
    b_ready_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (a_valid_o && qa.size() != 0) chk("st_a_tail", a_data_o, qa.pop_front());
      if (b_valid_o && qb.size() != 0) chk("st_b_tail", b_data_o, qb.pop_front());
      tick();
    end
    chk("st_a_empty", 32'(a_count_o), 32'd0);
    chk("st_b_empty", 32'(b_count_o), 32'd0);
    chk("st_a_left",  32'(qa.size()), 32'd0);
    chk("st_b_left",  32'(qb.size()), 32'd0);

`ifdef STREAM_DEMUX_PERF_CNT_EN
    do_reset();
    chk("perf_rst_a", a_xfer_cnt_o, 32'd0);
    chk("perf_rst_s", stall_cnt_o,  32'd0);
    a_ready_i = 1'b1;
    b_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      push(1'b0, 32'hD000_0000 + 32'(i));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      push(1'b1, 32'hE000_0000 + 32'(i));
      tick();
    end
    in_valid_i = 1'b0;
    tick();
    a_ready_i = 1'b0;
    push(1'b0, 32'hF000_0000);
    tick();
    push(1'b0, 32'hF000_0001);
    tick();
    push(1'b0, 32'hF000_0002);
    tick();
    tick();
    tick();
    in_valid_i = 1'b0;
    #1;
    chk("perf_a_xfer", a_xfer_cnt_o, 32'd7);
    chk("perf_b_xfer", b_xfer_cnt_o, 32'd4);
    chk("perf_stall",  stall_cnt_o,  32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_demux_1to2.md
Name: stream_demux_1to2

Overview:
- Sequential 1-to-2 steering block; the inverse direction of the datapath 2:1 word select.
- Takes one valid/ready stream of 32-bit words plus a per-word select and delivers each word to output port A (se_i=0) or port B (se_i=1).
- Each output has its own small FIFO, so a stalled consumer blocks only words destined for it.
- Used to split CPU-side response traffic toward two independent consumers.

Parameters:
- DW, 32, data word width.
- DEPTH, 2, entries per output FIFO; power of two, minimum 2.
- CW, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous reset, active-high.
- in_valid_i  input  1  input word valid.
- in_ready_o  output  1  input word accepted this cycle when high with in_valid_i.
- in_data_i  input  DW  input word.
- se_i  input  1  destination select, sampled with the word: 0 -> A, 1 -> B.
- a_valid_o  output  1  port A head valid.
- a_ready_i  input  1  port A consumer ready.
- a_data_o  output  DW  port A head word.
- b_valid_o  output  1  port B head valid.
- b_ready_i  input  1  port B consumer ready.
- b_data_o  output  DW  port B head word.
- a_count_o  output  CW  port A FIFO occupancy.
- b_count_o  output  CW  port B FIFO occupancy.

Behaviour:
- Reset, synchronous and active-high, applies on any cycle, including mid-transfer. It clears pointers and counts and discards FIFO contents. After reset, in_ready_o=1 and all valid, data and count outputs are 0.
- in_ready_o = !full(selected FIFO). Computed from registered full flags and se_i only; no combinational path from a_ready_i or b_ready_i.
- Push: in_valid_i & in_ready_o writes in_data_i into the FIFO chosen by se_i.
- Pop: x_valid_o & x_ready_i advances the read pointer of port x.
- Latency: a word pushed at edge N is visible on x_valid_o/x_data_o after edge N (1 cycle) if that FIFO was empty.
- x_valid_o = (count != 0). x_data_o = head entry when valid, forced to 0 when not valid.
- Simultaneous push and pop on the same FIFO: both occur and the count is unchanged. This is legal only if the FIFO is not full at the push; a full FIFO refuses the push even while popping.
- Push to one FIFO and pop from the other in the same cycle are independent.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH. Count range is 0..DEPTH.
- Per-port ordering is preserved. No ordering guarantee between A and B.
- A full FIFO for the selected port deasserts in_ready_o. The upstream must hold in_data_i and se_i stable while in_valid_i is high and unaccepted.
- Pop on an empty FIFO cannot occur, because valid is low.
- Changing se_i while stalled is an upstream protocol violation. The block does not check for it and simply evaluates ready against the current se_i.

Optional Feature:
- Macro: STREAM_DEMUX_PERF_CNT_EN.
- Defined: adds three outputs, each 32 bits wide, reset to 0:
  - a_xfer_cnt_o: counts port-A pops.
  - b_xfer_cnt_o: counts port-B pops.
  - stall_cnt_o: counts cycles with in_valid_i & !in_ready_o.
  - All three wrap modulo 2^32.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package stream_demux_pkg holds:
  - localparam DW_DEF=32 and DEPTH_DEF=2.
  - typedef word_t (logic [31:0]).
  - typedef port_sel_e with PORT_A=1'b0 and PORT_B=1'b1.
- One sub-module, stream_demux_fifo: synchronous FIFO with push, pop, wdata, rdata, full, empty and count, all on clk_i/rst_i.
- The top instantiates it twice and adds the steering, in_ready_o and optional counters.

Test Plan:
- Reset: assert rst_i for 2 cycles during traffic -> next cycle in_ready_o=1, a/b_valid_o=0, a/b_data_o=0, counts=0.
- Steering: push 0x11111111 (se_i=0) then 0x22222222 (se_i=1), both ports ready -> A shows 0x11111111 the cycle after the first push, B shows 0x22222222 the cycle after the second push.
- Full/back-pressure:
  - Hold a_ready_i=0 and push 3 words to A (DEPTH=2) -> a_count_o=2 and in_ready_o=0 for the third word.
  - Meanwhile a push with se_i=1 is accepted and appears on B.
- Simultaneous push/pop: A at count 1, push to A with a_ready_i=1 -> a_count_o stays 1; FIFO order is kept across a pointer wrap after 5 round-trips.
- Random stress: 10k random words, random se_i and random ready toggling -> per-port scoreboard matches, with no loss or reordering.
- With STREAM_DEMUX_PERF_CNT_EN: 7 A pops, 4 B pops and 3 stall cycles -> a_xfer_cnt_o=7, b_xfer_cnt_o=4, stall_cnt_o=3.
